// File: rtl/cache_controller.sv
// cache_pkg: geometry and storage types for the direct-mapped write-through cache.
//
// cache_controller: sequences lookups, read-miss refills and write-through
// stores. It holds the tag/valid array in flops and drives the external
// one-cycle-latency data SRAM and the memory bus.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   flush_i                        invalidate all sets (honoured in IDLE only)
//   req_*                          requester handshake, op, address, write data
//   rsp_valid_o, rsp_rdata_o       one-cycle response pulse and read data
//   sram_*                         data SRAM port
//   mem_*                          memory bus request / read response
//   hit_count_o, miss_count_o      performance counters
//
// Optional feature: define CACHE_PERF_CNT_EN to build the saturating hit/miss
// counters. Without it, both counter ports are tied to zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request or a flush; read issues the SRAM read
// LOOKUP    | SRAM data returns; tag compare decides hit or miss
// MISS_REQ  | memory read request held until accepted
// MISS_WAIT | waiting for refill data; refill SRAM, tag and respond
// WRITE     | memory write held until accepted; update SRAM on a hit

package cache_pkg;
  localparam int NumSets   = 16;
  localparam int TagWidth  = 8;
  localparam int DataWidth = 16;
  localparam int SetWidth  = $clog2(NumSets);
  localparam int AddrWidth = TagWidth + SetWidth;

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  typedef logic [DataWidth-1:0] block_data_t;
endpackage

module cache_controller
  import cache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_en_o,
  output logic                 sram_we_o,
  output logic [SetWidth-1:0]  sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [15:0]          hit_count_o,
  output logic [15:0]          miss_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    WRITE
  } state_t;

  state_t               state;
  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  block_data_t          wdata_q;
  block_info_t          info [NumSets];

  logic [SetWidth-1:0]  set_q;
  logic [TagWidth-1:0]  tag_q;
  logic                 hit;
  logic                 accept;

  assign set_q  = addr_q[SetWidth-1:0];
  assign tag_q  = addr_q[AddrWidth-1:SetWidth];
  assign hit    = info[set_q].valid && (info[set_q].tag == tag_q);
  assign accept = req_ready_o && req_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      for (int i = 0; i < NumSets; i++) info[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            for (int i = 0; i < NumSets; i++) info[i].valid <= 1'b0;
          end else if (req_valid_i) begin
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
            state   <= req_we_i ? WRITE : LOOKUP;
          end
        end
        LOOKUP:    state <= hit ? IDLE : MISS_REQ;
        MISS_REQ:  if (mem_req_ready_i) state <= MISS_WAIT;
        MISS_WAIT: begin
          if (mem_rsp_valid_i) begin
            info[set_q] <= '{valid: 1'b1, tag: tag_q};
            state       <= IDLE;
          end
        end
        WRITE:     if (mem_req_ready_i) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state and same-cycle inputs: the SRAM read
  // must launch in the accept cycle and hit data is forwarded straight from
  // the SRAM, so registering them would add a cycle to every path.
  always_comb begin
    req_ready_o     = (state == IDLE) && !flush_i;
    rsp_valid_o     = 1'b0;
    rsp_rdata_o     = '0;
    sram_en_o       = 1'b0;
    sram_we_o       = 1'b0;
    sram_addr_o     = '0;
    sram_wdata_o    = '0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    case (state)
      IDLE: begin
        if (accept && !req_we_i) begin
          sram_en_o   = 1'b1;
          sram_addr_o = req_addr_i[SetWidth-1:0];
        end
      end
      LOOKUP: begin
        if (hit) begin
          rsp_valid_o = 1'b1;
          rsp_rdata_o = sram_rdata_i;
        end
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = addr_q;
      end
      MISS_WAIT: begin
        if (mem_rsp_valid_i) begin
          sram_en_o    = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = set_q;
          sram_wdata_o = mem_rdata_i;
          rsp_valid_o  = 1'b1;
          rsp_rdata_o  = mem_rdata_i;
        end
      end
      WRITE: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = addr_q;
        mem_wdata_o     = wdata_q;
        if (mem_req_ready_i) begin
          rsp_valid_o = 1'b1;
          // no write-allocate: only a resident line is updated
          if (hit) begin
            sram_en_o    = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = set_q;
            sram_wdata_o = wdata_q;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  // Counters survive a flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count_o != 16'hFFFF) hit_count_o <= hit_count_o + 16'd1;
      end else begin
        if (miss_count_o != 16'hFFFF) miss_count_o <= miss_count_o + 16'd1;
      end
    end
  end
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
  import cache_pkg::*;

`ifdef CACHE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 req_valid_i = 1'b0;
  logic                 req_ready_o;
  logic                 req_we_i = 1'b0;
  logic [AddrWidth-1:0] req_addr_i = '0;
  logic [DataWidth-1:0] req_wdata_i = '0;
  logic                 rsp_valid_o;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic                 sram_en_o, sram_we_o;
  logic [SetWidth-1:0]  sram_addr_o;
  logic [DataWidth-1:0] sram_wdata_o;
  logic [DataWidth-1:0] sram_rdata_i = '0;
  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i = 1'b0;
  logic                 mem_we_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic                 mem_rsp_valid_i = 1'b0;
  logic [DataWidth-1:0] mem_rdata_i = '0;
  logic [15:0]          hit_count_o, miss_count_o;

  cache_controller dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  // external data SRAM, one-cycle read latency
  logic [DataWidth-1:0] sram [NumSets];
  always @(posedge clk_i) begin
    if (sram_en_o) begin
      if (sram_we_o) sram[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i      <= sram[sram_addr_o];
    end
  end

  // reference model: main memory contents plus which block each set holds
  logic [DataWidth-1:0] mem_m [1 << AddrWidth];
  logic                 vld_m [NumSets];
  logic [TagWidth-1:0]  tag_m [NumSets];
  int                   hits_m, misses_m;

  int n_pass = 0, n_total = 0;
  int last_lat;
  logic [DataWidth-1:0] last_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NumSets; i++) begin
      vld_m[i] = 1'b0;
      tag_m[i] = '0;
    end
    hits_m = 0;
    misses_m = 0;
  endtask

  task automatic check_counters();
    check("hit_count", 32'(hit_count_o), PerfEn ? 32'(hits_m) : 32'd0);
    check("miss_count", 32'(miss_count_o), PerfEn ? 32'(misses_m) : 32'd0);
  endtask

  // One request from acceptance to response. rw = cycles memory holds ready
  // low, sw = extra cycles before read data returns. Starts and ends just after
  // a rising edge.
  task automatic do_req(input logic we, input logic [AddrWidth-1:0] addr,
                        input logic [DataWidth-1:0] wdata, input int rw, input int sw);
    logic [SetWidth-1:0] set;
    logic [TagWidth-1:0] tag;
    logic exp_hit, got, pend;
    logic [DataWidth-1:0] exp_data;
    int exp_lat, stall, rcnt, mem_hs, sram_wr, exp_sram_wr;
    set = addr[SetWidth-1:0];
    tag = addr[AddrWidth-1:SetWidth];
    exp_hit = vld_m[set] && (tag_m[set] == tag);
    exp_data = we ? wdata : mem_m[addr];
    if (we) begin
      exp_lat = 1 + rw;
      exp_sram_wr = exp_hit ? 1 : 0;
    end else begin
      exp_lat = exp_hit ? 1 : 3 + rw + sw;
      exp_sram_wr = exp_hit ? 0 : 1;
    end
    req_valid_i = 1'b1;
    req_we_i = we;
    req_addr_i = addr;
    req_wdata_i = wdata;
    @(negedge clk_i);
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    got = 1'b0; pend = 1'b0; stall = 0; rcnt = 0; mem_hs = 0; sram_wr = 0; last_lat = -1;
    for (int k = 1; k <= 40 && !got; k++) begin
      mem_req_ready_i = 1'b0;
      if (mem_req_valid_o) begin
        if (stall < rw) stall++;
        else mem_req_ready_i = 1'b1;
      end
      if (pend) begin
        if (rcnt == sw) begin
          mem_rsp_valid_i = 1'b1;
          mem_rdata_i = mem_m[addr];
          pend = 1'b0;
        end else rcnt++;
      end
      @(negedge clk_i);
      if (mem_req_valid_o) begin
        check("mem_addr", 32'(mem_addr_o), 32'(addr));
        check("mem_we", 32'(mem_we_o), 32'(we));
        if (we) check("mem_wdata", 32'(mem_wdata_o), 32'(wdata));
        check("req_ready_busy", 32'(req_ready_o), 32'd0);
        if (mem_req_ready_i) begin
          mem_hs++;
          if (!we) pend = 1'b1;
        end
      end
      if (sram_en_o && sram_we_o) begin
        sram_wr++;
        check("sram_waddr", 32'(sram_addr_o), 32'(set));
        check("sram_wdata", 32'(sram_wdata_o), 32'(exp_data));
      end
      if (rsp_valid_o) begin
        got = 1'b1;
        last_lat = k;
        last_rdata = rsp_rdata_o;
        if (!we) check("rsp_rdata", 32'(rsp_rdata_o), 32'(exp_data));
      end
      @(posedge clk_i); #1;
      mem_rsp_valid_i = 1'b0;
      mem_req_ready_i = 1'b0;
    end
    check("rsp_latency", 32'(last_lat), 32'(exp_lat));
    check("mem_handshakes", 32'(mem_hs), (we || !exp_hit) ? 32'd1 : 32'd0);
    check("sram_writes", 32'(sram_wr), 32'(exp_sram_wr));
    if (we) mem_m[addr] = wdata;
    else if (exp_hit) hits_m++;
    else begin
      misses_m++;
      vld_m[set] = 1'b1;
      tag_m[set] = tag;
    end
    check_counters();
  endtask

  task automatic rd(input logic [AddrWidth-1:0] addr, input int rw, input int sw);
    do_req(1'b0, addr, '0, rw, sw);
  endtask

  initial begin
    for (int i = 0; i < (1 << AddrWidth); i++) mem_m[i] = 16'(i * 7 + 16'h1000);
    for (int i = 0; i < NumSets; i++) sram[i] = '0;
    mem_m[12'h123] = 16'hBEEF;
    mem_m[12'h223] = 16'hCAFE;
    model_reset();

    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_sram_en", 32'(sram_en_o), 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    check_counters();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // cold miss, then hit
    rd(12'h123, 0, 0);
    check("cold_lat_lit", 32'(last_lat), 32'd3);
    check("cold_data_lit", 32'(last_rdata), 32'hBEEF);
    rd(12'h123, 0, 0);
    check("hit_lat_lit", 32'(last_lat), 32'd1);
    check("hit_data_lit", 32'(last_rdata), 32'hBEEF);
    check("hit_cnt_lit", 32'(hit_count_o), PerfEn ? 32'd1 : 32'd0);
    check("miss_cnt_lit", 32'(miss_count_o), PerfEn ? 32'd1 : 32'd0);

    // conflict in set 3
    rd(12'h223, 0, 2);
    check("conflict_lat_lit", 32'(last_lat), 32'd5);
    check("conflict_data_lit", 32'(last_rdata), 32'hCAFE);
    rd(12'h123, 0, 0);
    check("evicted_lat_lit", 32'(last_lat), 32'd3);

    // write-through on a resident line, then a non-resident one
    do_req(1'b1, 12'h123, 16'h1234, 1, 0);
    check("wr_lat_lit", 32'(last_lat), 32'd2);
    rd(12'h123, 0, 0);
    check("wr_hit_data_lit", 32'(last_rdata), 32'h1234);
    do_req(1'b1, 12'h0F7, 16'h5555, 0, 0);
    rd(12'h0F7, 0, 1);
    check("wr_miss_data_lit", 32'(last_rdata), 32'h5555);

    // flush in IDLE
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    model_flush: for (int i = 0; i < NumSets; i++) vld_m[i] = 1'b0;
    rd(12'h123, 0, 0);
    check("flush_miss_lit", 32'(last_lat), 32'd3);

    // memory backpressure on a miss
    rd(12'h345, 5, 0);
    check("bp_lat_lit", 32'(last_lat), 32'd8);
    rd(12'h345, 0, 0);

    // reset while waiting for refill data, then a stray response
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 12'h456;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    check("abort_mem_valid", 32'(mem_req_valid_o), 32'd1);
    @(posedge clk_i); #1;
    mem_req_ready_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("abort_rsp", 32'(rsp_valid_o), 32'd0);
    check("abort_req_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = 16'hDEAD;
    @(negedge clk_i);
    check("stray_rsp", 32'(rsp_valid_o), 32'd0);
    check("stray_sram", 32'(sram_en_o), 32'd0);
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    check_counters();
    rd(12'h456, 0, 0);
    check("abort_set_invalid_lit", 32'(last_lat), 32'd3);
    rd(12'h345, 0, 0);
    rd(12'h456, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
